// File: rtl/spiifc_mem.sv
`default_nettype none
// ============================================================================
// Module      : spiifc_mem
// Description : SPI slave bridging an external SPI master to a single-port
//               synchronous-read memory. Command/address header followed by
//               read or write data bursts with address auto-increment/wrap.
//               All four SPI modes; SPI pins are synchronised to SysClk.
// Revision    : 1.0 - initial release
// ============================================================================
module spiifc_mem #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  SysClk,
    input  logic                  Reset_n,
    input  logic                  SPI_CLK,
    input  logic                  SPI_MOSI,
    input  logic                  SPI_SS,
    output logic                  SPI_MISO,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic [DATA_WIDTH-1:0] MemRdData,
    output logic [DATA_WIDTH-1:0] MemWrData,
    output logic                  MemWrEn,
    output logic                  Busy,
    output logic                  WordDone
);

    localparam int c_MAXW  = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int c_CNT_W = (c_MAXW > 2) ? $clog2(c_MAXW) : 1;
    localparam logic [c_CNT_W-1:0] c_DW_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_AW_LAST = c_CNT_W'(ADDR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_prev;

    // Bring SPI pins into the SysClk domain; SCLK resets to its idle level
    // so that reset release never looks like an edge.
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_prev <= CPOL;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk, w_mosi, w_ss_n;
    logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;

    assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_n   = r_ss_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk & ~r_sclk_prev;
    assign w_fall   = ~w_sclk & r_sclk_prev;
    assign w_lead   = CPOL ? w_fall : w_rise;
    assign w_trail  = CPOL ? w_rise : w_fall;
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead : w_trail;

    // ------------------------------------------------------------------
    // Protocol state machine and memory interface
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [c_CNT_W-1:0]    r_tx_cnt;
    logic [DATA_WIDTH-2:0] r_rx_sh;
    logic [ADDR_WIDTH-2:0] r_addr_sh;
    logic                  r_is_write;
    logic [DATA_WIDTH-1:0] r_tx_sh;
    logic [DATA_WIDTH-1:0] r_prefetch;
    logic                  r_rd_issue;
    logic                  r_rd_cap;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_en;
    logic                  r_word_done;
    logic                  r_miso;

    logic [DATA_WIDTH-1:0] w_rx_word;
    logic [ADDR_WIDTH-1:0] w_addr_word;

    assign w_rx_word   = {r_rx_sh, w_mosi};
    assign w_addr_word = {r_addr_sh, w_mosi};

    // Header decode, data-word shifting, write strobes and read look-ahead.
    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_tx_cnt    <= '0;
            r_rx_sh     <= '0;
            r_addr_sh   <= '0;
            r_is_write  <= 1'b0;
            r_tx_sh     <= '0;
            r_prefetch  <= '0;
            r_rd_issue  <= 1'b0;
            r_rd_cap    <= 1'b0;
            r_mem_addr  <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_word_done <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_word_done <= 1'b0;
            r_rd_issue  <= 1'b0;
            r_rd_cap    <= r_rd_issue;

            // Read data lands one cycle after the address was presented;
            // park it and move on to the next address.
            if (r_rd_cap) begin
                r_prefetch <= MemRdData;
                r_mem_addr <= r_mem_addr + 1'b1;
            end
            // Address advances the cycle after the write strobe.
            if (r_wr_en) begin
                r_mem_addr <= r_mem_addr + 1'b1;
            end

            if (w_ss_n) begin
                // Deselected: abandon any partial word, quiet MISO.
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
                r_miso    <= 1'b0;
                r_rd_cap  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A sample edge coinciding with select counts as bit 0.
                        r_state   <= S_CMD;
                        r_bit_cnt <= '0;
                        if (w_sample) begin
                            r_rx_sh   <= w_rx_word[DATA_WIDTH-2:0];
                            r_bit_cnt <= c_CNT_W'(1);
                        end
                    end
                    S_CMD: begin
                        if (w_sample) begin
                            r_rx_sh <= w_rx_word[DATA_WIDTH-2:0];
                            if (r_bit_cnt == c_DW_LAST) begin
                                r_is_write <= r_rx_sh[DATA_WIDTH-2];
                                r_state    <= S_ADDR;
                                r_bit_cnt  <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sample) begin
                            r_addr_sh <= w_addr_word[ADDR_WIDTH-2:0];
                            if (r_bit_cnt == c_AW_LAST) begin
                                r_mem_addr <= w_addr_word;
                                r_bit_cnt  <= '0;
                                r_tx_cnt   <= '0;
                                if (r_is_write) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_state    <= S_RDATA;
                                    r_rd_issue <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_sample) begin
                            r_rx_sh <= w_rx_word[DATA_WIDTH-2:0];
                            if (r_bit_cnt == c_DW_LAST) begin
                                r_wr_data   <= w_rx_word;
                                r_wr_en     <= 1'b1;
                                r_word_done <= 1'b1;
                                r_bit_cnt   <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_shift) begin
                            if (r_tx_cnt == '0) begin
                                // Word boundary: present prefetched word and
                                // immediately fetch the one after it.
                                r_miso     <= r_prefetch[DATA_WIDTH-1];
                                r_tx_sh    <= {r_prefetch[DATA_WIDTH-2:0], 1'b0};
                                r_rd_issue <= 1'b1;
                            end else begin
                                r_miso  <= r_tx_sh[DATA_WIDTH-1];
                                r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
                            end
                            r_tx_cnt <= (r_tx_cnt == c_DW_LAST) ? '0 : r_tx_cnt + 1'b1;
                        end
                        if (w_sample) begin
                            if (r_bit_cnt == c_DW_LAST) begin
                                r_word_done <= 1'b1;
                                r_bit_cnt   <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign SPI_MISO  = r_miso;
    assign MemAddr   = r_mem_addr;
    assign MemWrData = r_wr_data;
    assign MemWrEn   = r_wr_en;
    assign WordDone  = r_word_done;
    assign Busy      = ~w_ss_n;

endmodule
`default_nettype wire

// File: tb/tb_spiifc_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_spiifc_mem
// Description : Self-checking bench for spiifc_mem. Four instances (mode 0,
//               mode 3, mode 1, and a 16-bit/10-bit mode 0) share one SPI
//               bus with separate selects; each has a synchronous-read RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spiifc_mem;

    localparam int c_HALF = 80;

    typedef struct {
        int dut;
        int addr;
        int data;
    } wr_t;

    logic       SysClk;
    logic       Reset_n;
    logic       sck;
    logic       sck_n;
    logic       mosi;
    logic       preload;
    logic [3:0] ss;
    logic [3:0] miso, busy, we, wdn;

    logic [11:0] a0, a3, a1;
    logic [9:0]  a16;
    logic [7:0]  wd0, wd3, wd1, rd0, rd3, rd1;
    logic [15:0] wd16, rd16;

    logic [7:0]  m0  [4096];
    logic [7:0]  m3  [4096];
    logic [7:0]  m1  [4096];
    logic [15:0] m16 [1024];

    logic [31:0] waddr [4];
    logic [31:0] wdat  [4];

    int  total = 0;
    int  bad   = 0;
    int  wdc [4] = '{default: 0};
    int  wrc [4] = '{default: 0};
    wr_t exp_q [$];
    int  rd_q  [$];
    wr_t mon_e;

    assign sck_n = ~sck;

    spiifc_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_m0 (
        .SysClk(SysClk), .Reset_n(Reset_n), .SPI_CLK(sck), .SPI_MOSI(mosi), .SPI_SS(ss[0]),
        .SPI_MISO(miso[0]), .MemAddr(a0), .MemRdData(rd0), .MemWrData(wd0), .MemWrEn(we[0]),
        .Busy(busy[0]), .WordDone(wdn[0]));

    spiifc_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_m3 (
        .SysClk(SysClk), .Reset_n(Reset_n), .SPI_CLK(sck_n), .SPI_MOSI(mosi), .SPI_SS(ss[1]),
        .SPI_MISO(miso[1]), .MemAddr(a3), .MemRdData(rd3), .MemWrData(wd3), .MemWrEn(we[1]),
        .Busy(busy[1]), .WordDone(wdn[1]));

    spiifc_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u_m1 (
        .SysClk(SysClk), .Reset_n(Reset_n), .SPI_CLK(sck), .SPI_MOSI(mosi), .SPI_SS(ss[2]),
        .SPI_MISO(miso[2]), .MemAddr(a1), .MemRdData(rd1), .MemWrData(wd1), .MemWrEn(we[2]),
        .Busy(busy[2]), .WordDone(wdn[2]));

    spiifc_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_w16 (
        .SysClk(SysClk), .Reset_n(Reset_n), .SPI_CLK(sck), .SPI_MOSI(mosi), .SPI_SS(ss[3]),
        .SPI_MISO(miso[3]), .MemAddr(a16), .MemRdData(rd16), .MemWrData(wd16), .MemWrEn(we[3]),
        .Busy(busy[3]), .WordDone(wdn[3]));

    assign waddr[0] = 32'(a0);
    assign waddr[1] = 32'(a3);
    assign waddr[2] = 32'(a1);
    assign waddr[3] = 32'(a16);
    assign wdat[0]  = 32'(wd0);
    assign wdat[1]  = 32'(wd3);
    assign wdat[2]  = 32'(wd1);
    assign wdat[3]  = 32'(wd16);

    initial begin
        SysClk = 1'b0;
        forever #5 SysClk = ~SysClk;
    end

    // Block RAM models with one-cycle synchronous read
    always @(posedge SysClk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) m0[i] <= i[7:0];
        end else if (we[0]) begin
            m0[a0] <= wd0;
        end
        rd0 <= m0[a0];
        if (we[1]) m3[a3] <= wd3;
        rd3 <= m3[a3];
        if (we[2]) m1[a1] <= wd1;
        rd1 <= m1[a1];
        if (we[3]) m16[a16] <= wd16;
        rd16 <= m16[a16];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the oldest expected write
    always @(negedge SysClk) begin
        for (int k = 0; k < 4; k++) begin
            if (wdn[k]) wdc[k] = wdc[k] + 1;
            if (we[k]) begin
                wrc[k] = wrc[k] + 1;
                check("wr_expected", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_dut", 128'(k), 128'(mon_e.dut));
                    check("wr_addr", 128'(waddr[k]), 128'(mon_e.addr));
                    check("wr_data", 128'(wdat[k]), 128'(mon_e.data));
                end
            end
        end
    end

    // SPI master; bus is mode-neutral, each DUT sees sck xor its CPOL
    task automatic xfer(input int idx, input int cpha, input int nbits,
                        input logic [127:0] tx, output logic [127:0] rx);
        rx = '0;
        @(negedge SysClk);
        ss[idx] = 1'b0;
        #(c_HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (cpha == 0) begin
                mosi = tx[i];
                #(c_HALF);
                rx[i] = miso[idx];
                sck = 1'b1;
                #(c_HALF);
                sck = 1'b0;
            end else begin
                sck = 1'b1;
                mosi = tx[i];
                #(c_HALF);
                rx[i] = miso[idx];
                sck = 1'b0;
                #(c_HALF);
            end
        end
        #(c_HALF);
        ss[idx] = 1'b1;
        mosi = 1'b0;
        #(6 * c_HALF);
    endtask

    initial begin
        logic [127:0] rx;
        int base_wd;
        int base_wr;
        int ev;

        Reset_n = 1'b0;
        sck     = 1'b0;
        mosi    = 1'b0;
        ss      = 4'hF;
        preload = 1'b0;
        repeat (4) @(negedge SysClk);
        check("reset_dut0", 128'({miso[0], busy[0], we[0], wdn[0], a0, wd0}), 128'(0));
        check("reset_others", 128'({miso[3:1], busy[3:1], we[3:1], wdn[3:1], a3, a1, a16, wd3, wd1, wd16}), 128'(0));
        preload = 1'b1;
        @(negedge SysClk);
        preload = 1'b0;
        Reset_n = 1'b1;
        repeat (4) @(negedge SysClk);

        // Mode 0 read burst of 4 words from 0x010
        for (int w = 0; w < 4; w++) rd_q.push_back(16 + w);
        base_wd = wdc[0];
        base_wr = wrc[0];
        xfer(0, 0, 52, 128'({8'h00, 12'h010, 32'h0}), rx);
        for (int w = 0; w < 4; w++) begin
            ev = rd_q.pop_front();
            check("m0_rd_word", 128'(rx[31 - 8*w -: 8]), 128'(ev));
        end
        check("m0_rd_worddone", 128'(wdc[0] - base_wd), 128'(4));
        check("m0_rd_no_write", 128'(wrc[0] - base_wr), 128'(0));

        // Mode 0 write burst wrapping past the top address
        exp_q.push_back('{0, 12'hFFE, 8'hA5});
        exp_q.push_back('{0, 12'hFFF, 8'h5A});
        exp_q.push_back('{0, 12'h000, 8'h3C});
        base_wd = wdc[0];
        xfer(0, 0, 44, 128'({8'h80, 12'hFFE, 8'hA5, 8'h5A, 8'h3C}), rx);
        check("m0_wr_worddone", 128'(wdc[0] - base_wd), 128'(3));
        check("m0_mem_ffe", 128'(m0[12'hFFE]), 128'(8'hA5));
        check("m0_mem_fff", 128'(m0[12'hFFF]), 128'(8'h5A));
        check("m0_mem_000", 128'(m0[12'h000]), 128'(8'h3C));
        check("m0_wr_drained", 128'(exp_q.size()), 128'(0));

        // SS raised 5 bits into the second word: only the first is written
        exp_q.push_back('{0, 12'h050, 8'h77});
        base_wd = wdc[0];
        xfer(0, 0, 33, 128'({8'h80, 12'h050, 8'h77, 5'b10001}), rx);
        check("abort_busy_low", 128'(busy[0]), 128'(0));
        check("abort_worddone", 128'(wdc[0] - base_wd), 128'(1));
        check("abort_mem_051", 128'(m0[12'h051]), 128'(8'h51));
        check("abort_drained", 128'(exp_q.size()), 128'(0));
        exp_q.push_back('{0, 12'h200, 8'h9D});
        xfer(0, 0, 28, 128'({8'h80, 12'h200, 8'h9D}), rx);
        check("after_abort_mem_200", 128'(m0[12'h200]), 128'(8'h9D));

        // Reset pulsed in the middle of a read burst of 0xFF data
        @(negedge SysClk);
        fork
            xfer(0, 0, 52, 128'({8'h00, 12'h0FF, 32'h0}), rx);
            begin
                #(3830);
                check("midrd_busy", 128'(busy[0]), 128'(1));
                check("midrd_miso", 128'(miso[0]), 128'(1));
                Reset_n = 1'b0;
                #1;
                check("midrd_reset_outputs", 128'({miso[0], busy[0], we[0], wdn[0], a0, wd0}), 128'(0));
                #19;
                Reset_n = 1'b1;
            end
        join
        repeat (4) @(negedge SysClk);

        // Post-reset readback of the wrapped write
        rd_q.push_back(8'hA5);
        rd_q.push_back(8'h5A);
        rd_q.push_back(8'h3C);
        xfer(0, 0, 44, 128'({8'h00, 12'hFFE, 24'h0}), rx);
        for (int w = 0; w < 3; w++) begin
            ev = rd_q.pop_front();
            check("postrst_rd_word", 128'(rx[23 - 8*w -: 8]), 128'(ev));
        end

        // Mode 3 and mode 1 write + readback of 0xC3 at 0x123
        for (int d = 1; d <= 2; d++) begin
            exp_q.push_back('{d, 12'h123, 8'hC3});
            xfer(d, 1, 28, 128'({8'h80, 12'h123, 8'hC3}), rx);
            rd_q.push_back(8'hC3);
            xfer(d, 1, 28, 128'({8'h00, 12'h123, 8'h00}), rx);
            ev = rd_q.pop_front();
            check((d == 1) ? "mode3_readback" : "mode1_readback", 128'(rx[7:0]), 128'(ev));
        end

        // 16-bit data / 10-bit address instance with wrap
        exp_q.push_back('{3, 10'h3FF, 16'hBEEF});
        exp_q.push_back('{3, 10'h000, 16'h1234});
        xfer(3, 0, 58, 128'({16'h8000, 10'h3FF, 16'hBEEF, 16'h1234}), rx);
        check("w16_mem_3ff", 128'(m16[10'h3FF]), 128'(16'hBEEF));
        check("w16_mem_000", 128'(m16[10'h000]), 128'(16'h1234));
        rd_q.push_back(16'hBEEF);
        rd_q.push_back(16'h1234);
        xfer(3, 0, 58, 128'({16'h0000, 10'h3FF, 32'h0}), rx);
        ev = rd_q.pop_front();
        check("w16_rd_word0", 128'(rx[31:16]), 128'(ev));
        ev = rd_q.pop_front();
        check("w16_rd_word1", 128'(rx[15:0]), 128'(ev));

        check("all_writes_seen", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
